mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; a load/store responder on the CPU LSU bus at region BASE_ADDR.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [15:0] TXDATA_OFS = 16'h0000;
  localparam logic [15:0] STATUS_OFS = 16'h0004;
  localparam logic [15:0] CTRL_OFS   = 16'h0008;

  localparam int unsigned ST_EN    = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_BUSY  = 3;
  localparam int unsigned ST_OVR   = 4;

  function automatic logic [31:0] pack_status(
    input logic ovr,
    input logic busy,
    input logic empty,
    input logic full,
    input logic en
  );
    logic [31:0] s;
    s           = '0;
    s[ST_OVR]   = ovr;
    s[ST_BUSY]  = busy;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_EN]    = en;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; extra pointer MSB separates full from empty.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_uart_tx.sv
// LSU-mapped 8N1 UART transmitter: register decode, TX FIFO and serializer.
`timescale 1ns/1ps
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h1002
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wren,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned      CPB     = CLK_HZ / BAUD;
  localparam int unsigned      CNT_W   = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             hit;
  logic [15:0]      ofs;
  logic             wr_txdata;
  logic             wr_status;
  logic             wr_ctrl;
  logic             ctrl_en;
  logic             ctrl_ie;
  logic             ovr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic [31:0]      rd_val;
  logic             unused_bits;

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             tx_d;

  assign hit       = (i_addr[31:16] == BASE_ADDR) && (i_addr[1:0] == 2'b00);
  assign ofs       = i_addr[15:0];
  assign wr_txdata = i_wren && hit && (ofs == TXDATA_OFS);
  assign wr_status = i_wren && hit && (ofs == STATUS_OFS);
  assign wr_ctrl   = i_wren && hit && (ofs == CTRL_OFS);

  // Access size is irrelevant: only the low data byte is ever consumed.
  assign unused_bits = ^{i_func3, i_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (wr_txdata),
    .pop     (fifo_pop),
    .wdata   (i_wdata[7:0]),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_en <= 1'b1;
      ctrl_ie <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= i_wdata[0];
        ctrl_ie <= i_wdata[1];
      end
      if (wr_txdata && fifo_full && !fifo_pop) begin
        ovr <= 1'b1;
      end else if (wr_status && i_wdata[ST_OVR]) begin
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (ofs)
      STATUS_OFS: rd_val = pack_status(ovr, state_q != IDLE, fifo_empty, fifo_full, ctrl_en);
      CTRL_OFS:   rd_val = {30'd0, ctrl_ie, ctrl_en};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= (!i_wren && hit) ? rd_val : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Line level is computed for the upcoming cycle so o_tx comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty && ctrl_en) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
          cnt_d    = CNT_MAX;
          tx_d     = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_MAX;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          cnt_d = CNT_MAX;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == '0) begin
          if (!fifo_empty && ctrl_en) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
            cnt_d    = CNT_MAX;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_tx  = tx_q;
  assign o_irq = fifo_empty && (state_q == IDLE) && ctrl_ie;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: frame-level reference model predicts line waveform, start times and register reads.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;
  localparam logic [15:0] BASE  = 16'h1002;
  localparam logic [31:0] A_TX  = {BASE, 16'h0000};
  localparam logic [31:0] A_ST  = {BASE, 16'h0004};
  localparam logic [31:0] A_CT  = {BASE, 16'h0008};

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wren  = 1'b0;
  logic [31:0] i_addr  = '0;
  logic [31:0] i_wdata = '0;
  logic [2:0]  i_func3 = '0;
  logic [31:0] o_rdata;
  logic        o_tx;
  logic        o_irq;

  mmio_uart_tx #(
    .CLK_HZ     (1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wren  (i_wren),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_func3 (i_func3),
    .o_rdata (o_rdata),
    .o_tx    (o_tx),
    .o_irq   (o_irq)
  );

  initial forever #5 i_clk = ~i_clk;

  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Model: every accepted byte with the cycle its start bit appears (-1 while EN is off).
  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;
  frame_t hist[$];
  int     exp_q[$];

  typedef struct {
    int          cyc;
    logic [31:0] exp;
    string       name;
  } rd_t;
  rd_t rd_q[$];

  logic m_en  = 1'b1;
  logic m_ie  = 1'b0;
  logic m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int in_fifo(input int n);
    int c = 0;
    foreach (hist[i]) if (hist[i].start < 0 || hist[i].start > n) c++;
    return c;
  endfunction

  function automatic int staying(input int n);
    int c = 0;
    foreach (hist[i]) if (hist[i].start < 0 || hist[i].start > n + 1) c++;
    return c;
  endfunction

  function automatic logic busy(input int n);
    foreach (hist[i])
      if (hist[i].start >= 0 && hist[i].start <= n && n < hist[i].start + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int last_start();
    int l = -1000000;
    foreach (hist[i]) if (hist[i].start > l) l = hist[i].start;
    return l;
  endfunction

  function automatic logic [31:0] status_at(input int n);
    logic [31:0] s;
    int occ;
    occ  = in_fifo(n);
    s    = '0;
    s[4] = m_ovr;
    s[3] = busy(n);
    s[2] = (occ == 0);
    s[1] = (occ == DEPTH);
    s[0] = m_en;
    return s;
  endfunction

  function automatic logic irq_model(input int n);
    return m_ie && (in_fifo(n) == 0) && !busy(n);
  endfunction

  function automatic logic [31:0] read_model(input logic [31:0] addr, input int n);
    if (addr[31:16] != BASE || addr[1:0] != 2'b00) return '0;
    case (addr[15:0])
      16'h0004: return status_at(n);
      16'h0008: return {30'd0, m_ie, m_en};
      default:  return '0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input int n);
    frame_t f;
    logic   was_en;
    int     l;
    if (addr[31:16] != BASE || addr[1:0] != 2'b00) return;
    case (addr[15:0])
      16'h0000: begin
        if (staying(n) >= DEPTH) begin
          m_ovr = 1'b1;
        end else begin
          f.data  = data[7:0];
          f.start = m_en ? imax(n + 2, last_start() + FRAME) : -1;
          hist.push_back(f);
          exp_q.push_back(hist.size() - 1);
        end
      end
      16'h0004: if (data[4]) m_ovr = 1'b0;
      16'h0008: begin
        was_en = m_en;
        m_en   = data[0];
        m_ie   = data[1];
        if (!was_en && m_en) begin
          l = last_start();
          foreach (hist[i]) begin
            if (hist[i].start < 0) begin
              l             = imax(n + 2, l + FRAME);
              hist[i].start = l;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    rd_q.delete();
    m_en  = 1'b1;
    m_ie  = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Bus tasks are entered on a negedge and drive for exactly one cycle.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    i_wren  = 1'b1;
    i_addr  = addr;
    i_wdata = data;
    i_func3 = 3'($urandom_range(0, 2));
    model_store(addr, data, cyc);
    @(negedge i_clk);
  endtask

  task automatic load(input logic [31:0] addr, input string name);
    rd_t r;
    i_wren  = 1'b0;
    i_addr  = addr;
    i_wdata = $urandom;
    i_func3 = 3'd2;
    r.cyc   = cyc;
    r.exp   = read_model(addr, cyc);
    r.name  = name;
    rd_q.push_back(r);
    @(negedge i_clk);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      i_wren = 1'b0;
      i_addr = '0;
      @(negedge i_clk);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) idle(1);
  endtask

  task automatic drain();
    wait_until(last_start() + FRAME + 2);
    check("frames_outstanding", exp_q.size(), 0);
  endtask

  // Load monitor: compares o_rdata one cycle after each issued load.
  initial forever begin
    rd_t r;
    @(negedge i_clk);
    if (rd_q.size() > 0 && rd_q[0].cyc + 1 == cyc) begin
      r = rd_q.pop_front();
      check(r.name, o_rdata, r.exp);
    end
  end

  // Line monitor: every frame is checked sample by sample against the predicted byte.
  initial begin
    bit         in_frame;
    int         pos;
    int         cur;
    logic [9:0] bits;
    in_frame = 1'b0;
    pos      = 0;
    bits     = '1;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && o_tx !== 1'b1) begin
          if (exp_q.size() == 0) begin
            check("tx_idle_level", o_tx, 1'b1);
          end else begin
            cur      = exp_q.pop_front();
            bits     = {1'b1, hist[cur].data, 1'b0};
            in_frame = 1'b1;
            pos      = 0;
            if (hist[cur].start >= 0) check("frame_start_cycle", cyc, hist[cur].start);
          end
        end
        if (in_frame) begin
          check("tx_bit", o_tx, bits[pos / CPB]);
          pos++;
          if (pos == FRAME) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int h1;
    int s2;
    int op;
    repeat (3) @(negedge i_clk);
    check("rst_tx", o_tx, 1'b1);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_irq", o_irq, 1'b0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Reset-state register reads and decode misses
    load(A_ST, "status_after_reset");
    load({BASE, 16'h000C}, "read_unmapped_offset");
    load(32'h1003_0004, "read_other_base");
    load(A_CT, "ctrl_after_reset");
    load({BASE, 16'h0006}, "read_misaligned");
    idle(2);

    // Single frame with exact start latency
    store(A_TX, 32'h0000_0055);
    idle(FRAME + 4);

    // Back-to-back frames and interrupt after the final stop bit
    store(A_CT, 32'h3);
    store(A_TX, 32'h41);
    store(A_TX, 32'h42);
    s2 = hist[hist.size() - 1].start;
    wait_until(s2 + FRAME - 1);
    check("irq_during_last_stop", o_irq, irq_model(cyc));
    idle(1);
    check("irq_after_last_stop", o_irq, irq_model(cyc));
    check("irq_after_last_stop_set", o_irq, 1'b1);
    idle(2);

    // Overflow with transmitter disabled, OVR clear, then release
    store(A_CT, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) store(A_TX, 32'($urandom_range(0, 255)));
    load(A_ST, "status_full_ovr");
    store(A_ST, 32'h10);
    load(A_ST, "status_ovr_cleared");
    store(A_CT, 32'h1);
    drain();
    load(A_ST, "status_after_drain");

    // Push while full in the cycle a stop-end pop happens
    for (int i = 0; i < DEPTH + 1; i++) store(A_TX, 32'($urandom_range(0, 255)));
    h1 = hist.size() - DEPTH;
    load(A_ST, "status_full_before_pop");
    wait_until(hist[h1].start - 1);
    store(A_TX, 32'hA5);
    load(A_ST, "status_full_no_ovr");
    drain();

    // Randomized traffic including drops, decode misses and IE changes
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        op = $urandom_range(0, 11);
        if (op <= 5) store(A_TX, $urandom);
        else if (op == 6) load(A_ST, "rand_status");
        else if (op == 7) load(A_CT, "rand_ctrl");
        else if (op == 8) begin
          case ($urandom_range(0, 3))
            0: store({BASE, 16'h0001}, $urandom);
            1: store({BASE, 16'h000C}, $urandom);
            2: store(32'h1003_0000, $urandom);
            default: store({BASE, 16'h0102}, $urandom);
          endcase
        end
        else if (op == 9) store(A_ST, $urandom);
        else if (op == 10) store(A_CT, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
        else load(32'($urandom) & 32'hFFFF_000F | {BASE, 16'h0}, "rand_read");
        idle($urandom_range(0, 2));
      end
      check("irq_random", o_irq, irq_model(cyc));
      if ($urandom_range(0, 3) == 0) drain();
      else idle($urandom_range(0, 50));
    end
    drain();
    load(A_ST, "status_after_random");
    store(A_ST, 32'h10);
    idle(2);

    // Asynchronous reset in the middle of a data bit
    store(A_TX, 32'h00);
    wait_until(hist[hist.size() - 1].start + 3 * CPB);
    check("tx_low_mid_data", o_tx, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_tx", o_tx, 1'b1);
    check("async_rst_rdata", o_rdata, 32'h0);
    check("async_rst_irq", o_irq, 1'b0);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    load(A_ST, "status_after_midframe_reset");
    idle(FRAME + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
